// File: rtl/output_buffer_if.sv
// Stream bundle for output_buffer: input sample side and output entry side.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the source holds data stable while valid && !ready.
interface output_buffer_if #(
  parameter int WIDTH    = 9,
  parameter int IN_WIDTH = 12,
  parameter int CH       = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CH*IN_WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH*WIDTH-1:0]    out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/output_buffer.sv
// Rounding/scaling FIFO at the FFT output, with a registered head entry.
// Define OUTPUT_BUFFER_SAT_EN to clamp out-of-range results and report them on sat_flag.
module output_buffer #(
  parameter int WIDTH    = 9,
  parameter int IN_WIDTH = 12,
  parameter int SHIFT    = 3,
  parameter int CH       = 2,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  output_buffer_if.slave         bus,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   sat_flag
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CH*WIDTH + 1;
  localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH+1)'((2**SHIFT)/2);

  logic signed [IN_WIDTH:0] sum [CH];
  logic [CH*WIDTH-1:0]      scaled;
  logic [EW-1:0]            mem [DEPTH];
  logic [EW-1:0]            head_q;
  logic [AW-1:0]            wr_ptr, rd_ptr, rd_nxt;
  logic                     push, pop, load_new;

`ifdef OUTPUT_BUFFER_SAT_EN
  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'(2**(WIDTH-1) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = -SAT_MAX - (IN_WIDTH+1)'(1);
  logic signed [IN_WIDTH:0] r [CH];
  logic                     clip;
  logic                     sat_q;
`endif

  // Round-half-up then arithmetic shift, one extra bit of headroom for the rounding add.
  always_comb begin
    scaled = '0;
`ifdef OUTPUT_BUFFER_SAT_EN
    clip = 1'b0;
`endif
    for (int k = 0; k < CH; k++) begin
      sum[k] = $signed({bus.in_data[k*IN_WIDTH+IN_WIDTH-1], bus.in_data[k*IN_WIDTH +: IN_WIDTH]}) + RND;
`ifdef OUTPUT_BUFFER_SAT_EN
      r[k] = sum[k] >>> SHIFT;
      if (r[k] > SAT_MAX) begin
        scaled[k*WIDTH +: WIDTH] = WIDTH'(SAT_MAX);
        clip = 1'b1;
      end else if (r[k] < SAT_MIN) begin
        scaled[k*WIDTH +: WIDTH] = WIDTH'(SAT_MIN);
        clip = 1'b1;
      end else begin
        scaled[k*WIDTH +: WIDTH] = WIDTH'(r[k]);
      end
`else
      scaled[k*WIDTH +: WIDTH] = WIDTH'(sum[k] >>> SHIFT);
`endif
    end
  end

  // Both flags come from the count register only, so out_ready never reaches in_ready.
  assign bus.in_ready  = (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign rd_nxt        = rd_ptr + AW'(1);

  // The incoming sample becomes the head directly when nothing else is left to present.
  assign load_new = push && ((count == '0) || (pop && (count == CW'(1))));

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {bus.in_last, scaled};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (load_new)
        head_q <= {bus.in_last, scaled};
      else if (pop && (count > CW'(1)))
        head_q <= mem[rd_nxt];
    end
  end

`ifdef OUTPUT_BUFFER_SAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_q <= 1'b0;
    else if (flush)
      sat_q <= 1'b0;
    else if (push && clip)
      sat_q <= 1'b1;
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign bus.out_data = head_q[CH*WIDTH-1:0];
  assign bus.out_last = head_q[EW-1];
endmodule

// File: tb/tb_output_buffer.sv
// Directed + random bench for output_buffer with a queue-based scoreboard.
module tb_output_buffer;
  localparam int WIDTH    = 9;
  localparam int IN_WIDTH = 12;
  localparam int SHIFT    = 3;
  localparam int CH       = 2;
  localparam int DEPTH    = 4;
  localparam int EW       = CH*WIDTH + 1;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush;
  logic [2:0] count;
  logic       sat_flag;

  output_buffer_if #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .CH(CH)) bus ();

  output_buffer #(.WIDTH(WIDTH), .IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .CH(CH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .flush    (flush),
    .count    (count),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          sat_model = 1'b0;
  logic          accepted = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] scale1(input logic [IN_WIDTH-1:0] x, output logic clipped);
    int xi, r;
    xi = int'($signed(x));
    r  = (xi + (1 << (SHIFT-1))) >>> SHIFT;
    clipped = 1'b0;
`ifdef OUTPUT_BUFFER_SAT_EN
    if (r > (1 << (WIDTH-1)) - 1) begin
      r = (1 << (WIDTH-1)) - 1;
      clipped = 1'b1;
    end else if (r < -(1 << (WIDTH-1))) begin
      r = -(1 << (WIDTH-1));
      clipped = 1'b1;
    end
`endif
    return WIDTH'(r);
  endfunction

  function automatic logic [EW-1:0] model(input logic [CH*IN_WIDTH-1:0] d, input logic l, output logic clip_any);
    logic [EW-1:0] e;
    logic          c;
    e = '0;
    clip_any = 1'b0;
    e[EW-1] = l;
    for (int k = 0; k < CH; k++) begin
      e[k*WIDTH +: WIDTH] = scale1(d[k*IN_WIDTH +: IN_WIDTH], c);
      clip_any |= c;
    end
    return e;
  endfunction

  // One clock: score the pop/push about to happen, step the edge, then check state.
  task automatic cycle();
    logic [EW-1:0] e;
    logic          c;
    int            sz;
    sz = exp_q.size();
    accepted = 1'b0;
    if (flush) begin
      exp_q.delete();
      sat_model = 1'b0;
    end else begin
      if (sz != 0 && bus.out_ready)
        check("pop_data", 32'({bus.out_last, bus.out_data}), 32'(exp_q.pop_front()));
      if (bus.in_valid && sz < DEPTH) begin
        e = model(bus.in_data, bus.in_last, c);
        exp_q.push_back(e);
        if (c) sat_model = 1'b1;
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(exp_q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
    check("sat_flag", 32'(sat_flag), 32'(sat_model));
  endtask

  task automatic push_one(input logic [IN_WIDTH-1:0] c0, input logic [IN_WIDTH-1:0] c1, input logic l);
    bus.in_data  = {c1, c0};
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (accepted) break;
    end
    check("push_accepted", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [IN_WIDTH-1:0] rnd12();
    return IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
  endfunction

  initial begin
    logic [CH*WIDTH-1:0] exp_d;
    logic [WIDTH-1:0]    exp_c0;
    logic [CH*WIDTH-1:0] hold_d;
    int                  n;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    rstn          = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    @(negedge clk) rstn = 1'b1;
    #1 check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic rounding into an empty buffer, pushed on the first edge after release
    push_one(12'd100, 12'hFF3, 1'b0);
    exp_d = {9'h1FE, 9'd13};
    check("basic_data", 32'(bus.out_data), 32'(exp_d));
    check("basic_count", 32'(count), 32'd1);
    drain();

    // Positive and negative extremes
    push_one(12'd2047, 12'd0, 1'b0);
`ifdef OUTPUT_BUFFER_SAT_EN
    exp_c0 = 9'd255;
    check("max_sat", 32'(sat_flag), 32'd1);
`else
    exp_c0 = 9'h100;
    check("max_sat", 32'(sat_flag), 32'd0);
`endif
    hold_d = bus.out_data;
    check("max_data", 32'(hold_d[WIDTH-1:0]), 32'(exp_c0));
    drain();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_sat", 32'(sat_flag), 32'd0);
    push_one(12'h800, 12'd0, 1'b0);
    hold_d = bus.out_data;
    check("min_data", 32'(hold_d[WIDTH-1:0]), 32'h100);
    check("min_sat", 32'(sat_flag), 32'd0);
    drain();

    // Fill with out_ready low; fifth sample must wait for space
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(rnd12(), rnd12(), (i == 3));
    bus.in_data  = {rnd12(), rnd12()};
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    cycle();
    cycle();
    check("full_held", 32'(accepted), 32'd0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    n = 0;
    while (!accepted && n < 10) begin
      cycle();
      n++;
    end
    check("fifth_accepted", 32'(accepted), 32'd1);
    drain();

    // Sustained push and pop from full, pointers wrap twice
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(rnd12(), rnd12(), i[0]);
    bus.out_ready = 1'b1;
    bus.in_data   = {rnd12(), rnd12()};
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (accepted) begin
        bus.in_data = {rnd12(), rnd12()};
        bus.in_last = ($urandom_range(0, 1) == 1);
      end
    end
    drain();

    // Flush beats a concurrent push
    bus.out_ready = 1'b0;
    push_one(12'd2047, rnd12(), 1'b0);
    push_one(rnd12(), rnd12(), 1'b0);
    push_one(rnd12(), rnd12(), 1'b1);
    hold_d       = bus.out_data;
    flush        = 1'b1;
    bus.in_data  = {rnd12(), rnd12()};
    bus.in_valid = 1'b1;
    cycle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_sat2", 32'(sat_flag), 32'd0);
    check("flush_out_data", 32'(bus.out_data), 32'(hold_d));
    cycle();
    check("empty_hold_data", 32'(bus.out_data), 32'(hold_d));

    // Asynchronous reset mid-frame
    push_one(rnd12(), rnd12(), 1'b0);
    push_one(rnd12(), rnd12(), 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    exp_q.delete();
    sat_model = 1'b0;
    @(negedge clk) rstn = 1'b1;
    #1 check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    push_one(rnd12(), rnd12(), 1'b1);
    drain();

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      if (!bus.in_valid || accepted) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = {rnd12(), rnd12()};
        bus.in_last  = ($urandom_range(0, 3) == 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 9: output sample width per channel, signed two's complement.
REQ-002 SHALL have parameter IN_WIDTH, default 12: input sample width per channel, signed; IN_WIDTH >= WIDTH.
REQ-003 SHALL have parameter SHIFT, default 3: arithmetic right-shift applied with rounding; 0 <= SHIFT <= IN_WIDTH-1.
REQ-004 SHALL have parameter CH, default 2: channel count (e.g. real/imag), CH >= 1.
REQ-005 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, DEPTH >= 2.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  in_data/in_last valid this cycle.
REQ-009 in_ready  output  1  buffer can accept an entry this cycle.
REQ-010 in_data  input  CH*IN_WIDTH  channel k at bits [k*IN_WIDTH +: IN_WIDTH].
REQ-011 in_last  input  1  marks last sample of an FFT frame.
REQ-012 flush  input  1  synchronous clear of FIFO contents and sat_flag.
REQ-013 out_valid  output  1  out_data/out_last hold a valid entry.
REQ-014 out_ready  input  1  downstream accepts the entry this cycle.
REQ-015 out_data  output  CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH], registered.
REQ-016 out_last  output  1  frame marker travelling with out_data, registered.
REQ-017 count  output  $clog2(DEPTH)+1  entries currently held, including the one presented.
REQ-018 sat_flag  output  1  sticky; set when any channel of any accepted sample was clipped (SAT_EN builds only; tied 0 otherwise).

Function
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (count < DEPTH), registered-derived, with no combinational path from out_ready.
REQ-021 Per channel: r = (x + 2^(SHIFT-1)) >>> SHIFT computed in IN_WIDTH+1 bits (no rounding term when SHIFT=0), then narrowed to WIDTH per REQ-033/034.
REQ-022 Scaling SHALL be applied before storage; stored entry = CH scaled samples plus last bit.
REQ-023 Latency: a sample pushed into an empty buffer at edge t SHALL be on out_data with out_valid=1 after edge t.
REQ-024 Entries SHALL leave in push order; out_last SHALL accompany its own sample.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; when full, in_ready=0 so no push, a pop in that cycle frees one slot from the next cycle.
REQ-026 When empty, out_valid SHALL be 0 and out_data/out_last SHALL hold their previous values (no toggling, low-power).
REQ-027 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-028 flush SHALL take priority over push and pop in the same cycle: next count=0, out_valid=0, sat_flag=0, out_data held.
REQ-029 sat_flag SHALL stay set until flush or reset.

Reset
REQ-030 On rstn low, asynchronously: count=0, pointers=0, out_valid=0, out_data=0, out_last=0, sat_flag=0, in_ready=1 from release.
REQ-031 Reset asserted mid-frame SHALL discard all stored entries; no partial entry emerges after release.
REQ-032 First push SHALL be possible on the first rising edge after rstn rises.

Configuration
REQ-033 With macro OUTPUT_BUFFER_SAT_EN defined: r outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] SHALL clamp to nearest bound and set sat_flag.
REQ-034 Without OUTPUT_BUFFER_SAT_EN: r SHALL be truncated to its low WIDTH bits (wrap), sat_flag constant 0, no clamp logic synthesised.

Verification (WIDTH=9, IN_WIDTH=12, SHIFT=3, CH=2, DEPTH=4)
REQ-035 Push ch0=100, ch1=-13 into empty buffer -> next cycle out_valid=1, ch0=13, ch1=-2, count=1.
REQ-036 Push ch0=2047 -> SAT_EN: ch0=255, sat_flag=1; without: ch0=-256 (0x100), sat_flag=0; ch0=-2048 -> -256 in both, no flag.
REQ-037 out_ready=0, push 5 consecutive samples -> 4 accepted, in_ready=0 at count=4, 5th held; release out_ready -> samples emerge in order, last marker preserved.
REQ-038 Full buffer, in_valid=1 and out_ready=1 for 8 cycles -> one pop per cycle, push resumes, pointers wrap, no loss/duplication.
REQ-039 flush with in_valid=1 and count=3 -> next cycle count=0, out_valid=0, sat_flag=0, out_data unchanged, pushed sample dropped.
REQ-040 Assert rstn low with count=2 mid-frame -> immediately out_valid=0, out_data=0, count=0; after release in_ready=1.
